// File: rtl/add_chain_pipe.sv
// add_chain_pipe: three-stage pipelined evaluation of the chain
//   x = a + b,  y = x + c,  z = x + y   (all modulo 2^W)
// One register stage per dependency level, valid/ready on both sides.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand handshake; in_a, in_b, in_c operands
//   out_valid/out_ready   result handshake; out_x, out_y, out_z results
//   out_count             results accepted downstream (wraps at 2^CNT_W)
module add_chain_pipe #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [W-1:0]     in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_x,
  output logic [W-1:0]     out_y,
  output logic [W-1:0]     out_z,
  output logic [CNT_W-1:0] out_count
);

  logic [3:1]       vld_q, vld_d;
  logic [W-1:0]     x1_q, x1_d, c1_q, c1_d;
  logic [W-1:0]     x2_q, x2_d, y2_q, y2_d;
  logic [W-1:0]     x3_q, x3_d, y3_q, y3_d, z3_q, z3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy1, rdy2, rdy3;

  // Ready ripples back combinationally so a full pipe still moves one
  // beat per clock when the sink drains it.
  always_comb begin
    rdy3 = !vld_q[3] || out_ready;
    rdy2 = !vld_q[2] || rdy3;
    rdy1 = !vld_q[1] || rdy2;
  end

  always_comb begin
    vld_d = vld_q;
    x1_d  = x1_q;
    c1_d  = c1_q;
    x2_d  = x2_q;
    y2_d  = y2_q;
    x3_d  = x3_q;
    y3_d  = y3_q;
    z3_d  = z3_q;
    cnt_d = cnt_q;

    // Data of an invalid predecessor may be loaded; only vld matters.
    if (rdy1) begin
      vld_d[1] = in_valid;
      x1_d     = in_a + in_b;
      c1_d     = in_c;
    end
    if (rdy2) begin
      vld_d[2] = vld_q[1];
      x2_d     = x1_q;
      y2_d     = x1_q + c1_q;
    end
    if (rdy3) begin
      vld_d[3] = vld_q[2];
      x3_d     = x2_q;
      y3_d     = y2_q;
      z3_d     = x2_q + y2_q;
    end

    if (vld_q[3] && out_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      x1_q  <= '0;
      c1_q  <= '0;
      x2_q  <= '0;
      y2_q  <= '0;
      x3_q  <= '0;
      y3_q  <= '0;
      z3_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      x1_q  <= x1_d;
      c1_q  <= c1_d;
      x2_q  <= x2_d;
      y2_q  <= y2_d;
      x3_q  <= x3_d;
      y3_q  <= y3_d;
      z3_q  <= z3_d;
      cnt_q <= cnt_d;
    end
  end

  assign in_ready  = rdy1;
  assign out_valid = vld_q[3];
  assign out_x     = x3_q;
  assign out_y     = y3_q;
  assign out_z     = z3_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_add_chain_pipe.sv
// Directed bench for add_chain_pipe. Counter is narrowed to 2 bits so the
// wrap case stays short; all counts below are modulo 4.
module tb_add_chain_pipe;
  localparam int W     = 8;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]     in_a, in_b, in_c, out_x, out_y, out_z;
  logic [CNT_W-1:0] out_count;

  int tests = 0;
  int fails = 0;

  add_chain_pipe #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_c = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] z);
    chk({tag, "_v"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_x"}, {24'd0, out_x}, {24'd0, x});
    chk({tag, "_y"}, {24'd0, out_y}, {24'd0, y});
    chk({tag, "_z"}, {24'd0, out_z}, {24'd0, z});
  endtask

  initial begin
    // Reset with a beat presented: it must be discarded.
    rst_n = 1'b0; out_ready = 1'b1;
    beat(8'd9, 8'd9, 8'd9);
    tick(); tick();
    chk("rst_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_valid",  {31'd0, out_valid}, 32'd0);
    chk("rst_x",      {24'd0, out_x},     32'd0);
    chk("rst_z",      {24'd0, out_z},     32'd0);
    chk("rst_count",  {30'd0, out_count}, 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick(); tick(); tick();
    chk("rst_discard", {31'd0, out_valid}, 32'd0);

    // Single beat, latency 2 edges after accept.
    do_reset();
    beat(8'd10, 8'd20, 8'd30);
    chk("t1_ready", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    chk("t1_lat1", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t1_lat2", {31'd0, out_valid}, 32'd0);
    tick();
    chk_out("t1", 8'd30, 8'd60, 8'd90);
    tick();
    chk("t1_drain", {31'd0, out_valid}, 32'd0);
    chk("t1_count", {30'd0, out_count}, 32'd1);

    // Back-to-back beats.
    do_reset();
    beat(8'd10, 8'd20, 8'd30);
    chk("t2_ready0", {31'd0, in_ready}, 32'd1);
    tick();
    beat(8'd5, 8'd15, 8'd30);
    chk("t2_ready1", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    tick();
    chk_out("t2_b0", 8'd30, 8'd60, 8'd90);
    tick();
    chk_out("t2_b1", 8'd20, 8'd50, 8'd70);
    tick();
    chk("t2_count", {30'd0, out_count}, 32'd2);

    // Modulo-256 wrap of every sum.
    do_reset();
    beat(8'd200, 8'd100, 8'd50);
    tick(); in_valid = 1'b0;
    tick(); tick();
    chk_out("wrap", 8'd44, 8'd94, 8'd138);

    // Backpressure: fill three stages, fourth beat held.
    do_reset();
    out_ready = 1'b0;
    beat(8'd1, 8'd2, 8'd3);
    chk("bp_ready1", {31'd0, in_ready}, 32'd1);
    tick();
    beat(8'd4, 8'd5, 8'd6);
    chk("bp_ready2", {31'd0, in_ready}, 32'd1);
    tick();
    beat(8'd7, 8'd8, 8'd9);
    chk("bp_ready3", {31'd0, in_ready}, 32'd1);
    tick();
    beat(8'd10, 8'd11, 8'd12);
    chk("bp_full", {31'd0, in_ready}, 32'd0);
    chk_out("bp_stall0", 8'd3, 8'd6, 8'd9);
    tick();
    chk("bp_full2", {31'd0, in_ready}, 32'd0);
    chk_out("bp_stall1", 8'd3, 8'd6, 8'd9);
    out_ready = 1'b1;
    #1;
    chk("bp_release", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    chk_out("bp_o2", 8'd9, 8'd15, 8'd24);
    tick();
    chk_out("bp_o3", 8'd15, 8'd24, 8'd39);
    tick();
    chk_out("bp_o4", 8'd21, 8'd33, 8'd54);
    tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);
    chk("bp_count", {30'd0, out_count}, 32'd0);   // 4 mod 4

    // Reset mid-stream drops in-flight beats.
    do_reset();
    beat(8'd1, 8'd2, 8'd3);
    tick();
    beat(8'd4, 8'd5, 8'd6);
    tick(); in_valid = 1'b0;
    tick();
    chk_out("mid_pre", 8'd3, 8'd6, 8'd9);
    rst_n = 1'b0;
    tick();
    chk("mid_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_x",     {24'd0, out_x},     32'd0);
    chk("mid_y",     {24'd0, out_y},     32'd0);
    chk("mid_count", {30'd0, out_count}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("mid_gone", {31'd0, out_valid}, 32'd0);
    beat(8'd1, 8'd1, 8'd1);
    tick(); in_valid = 1'b0;
    tick(); tick();
    chk_out("mid_new", 8'd2, 8'd3, 8'd5);

    // Counter wrap: 5 accepted results on a 2-bit counter.
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      beat(i[W-1:0], 8'd0, 8'd0);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    chk_out("cw_last", 8'd5, 8'd5, 8'd10);
    chk("cw_zero", {30'd0, out_count}, 32'd0);
    tick();
    chk("cw_one", {30'd0, out_count}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/add_chain_pipe.md
Name: add_chain_pipe

Overview:
- Clocked, pipelined implementation of the three-term combinational chain x = a + b, y = x + c, z = x + y.
- Sits downstream of the stimulus/source stage and upstream of the result checker. It consumes {a,b,c} operand beats and produces registered {x,y,z} result beats.
- Uses a valid/ready handshake on both sides so that evaluation order is fixed by construction: one stage per dependency level.

Parameters:
- W, 8, operand and result width; all arithmetic is modulo 2^W.
- CNT_W, 16, width of the completed-transaction counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- in_valid  in  1  operand beat present
- in_ready  out  1  stage 1 can accept a beat this cycle
- in_a  in  W  operand a
- in_b  in  W  operand b
- in_c  in  W  operand c
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts the result this cycle
- out_x  out  W  a+b
- out_y  out  W  x+c
- out_z  out  W  x+y
- out_count  out  CNT_W  number of result beats accepted downstream

Behaviour:
- Pipeline is three register stages, each with its own valid bit v1, v2, v3.
  - S1 captures x1 = a+b and c1 = c.
  - S2 captures x2 = x1 and y2 = x1+c1.
  - S3 captures x3 = x2, y3 = y2 and z3 = x2+y2.
  - out_* are driven directly from the S3 registers; out_valid = v3.
- Ready chain is combinational and has no bubble penalty:
  - rdy3 = !v3 | out_ready
  - rdy2 = !v2 | rdy3
  - rdy1 = !v1 | rdy2
  - in_ready = rdy1
- Stage advance rules:
  - A stage loads from its predecessor when its own rdy is 1.
  - When rdy is 1, the stage's valid bit takes the predecessor's valid (in_valid for S1).
  - When rdy is 0, the stage holds its data and valid unchanged.
  - Data registers of invalid stages may load freely; only valid bits are significant.
- Latency: a beat accepted (in_valid & in_ready) at edge k shows out_valid=1 after edge k+2, provided out_ready stays high. Throughput is 1 beat per clock.
- Stall: while out_valid=1 and out_ready=0, out_x/out_y/out_z stay stable. Upstream stages keep filling until full, giving at most 3 beats in flight. in_ready drops only when all three stages are valid and out_ready=0.
- Simultaneous events:
  - With a full pipe, out_ready=1 and in_valid=1 in the same cycle, every stage shifts and one new beat is accepted; no loss, no duplication.
  - Ordering is strictly FIFO.
- Arithmetic: every sum is truncated to W bits with no carry, saturation or overflow flag. Sums use the truncated x, so the bench's expected values must also wrap x before computing y and z.
- out_count increments by 1 on each edge where out_valid & out_ready, and wraps from 2^CNT_W-1 to 0.
- Reset: rst_n=0 at an edge clears v1, v2, v3 and out_count, regardless of in-flight beats.
  - Data registers reset to 0, so out_x=out_y=out_z=0 after reset.
  - out_valid=0 after reset.
  - in_ready=1 combinationally during and after reset, since all valids are 0. Beats presented while rst_n=0 are discarded.
  - Reset mid-stream drops all in-flight beats; the first beat after reset release behaves as from an empty pipe.
- No X propagation: outputs are defined from the first edge with rst_n=0.

Test Plan:
- Reset, then one beat a=10, b=20, c=30 with out_ready=1 -> out_valid high exactly 2 edges after accept; x=30, y=60, z=90; out_count=1.
- Back-to-back beats (10,20,30) then (5,15,30) on consecutive cycles, out_ready=1 -> consecutive out beats (30,60,90) then (20,50,70); out_count=2; in_ready never low.
- Wrap: a=200, b=100, c=50 -> x=44, y=94, z=138 (all mod 256).
- Backpressure: hold out_ready=0 while streaming beats (1,2,3), (4,5,6), (7,8,9), (10,11,12) -> in_ready falls after the 3rd accept; the 4th is held. out_x/y/z stay at (3,6,9) while stalled. Release out_ready -> outputs (3,6,9), (9,15,24), (15,24,39), (21,33,54) in order with no loss.
- Reset mid-stream: 2 beats in flight, pulse rst_n=0 for 1 cycle -> out_valid=0, outputs=0, out_count=0; a new beat (1,1,1) yields (2,3,5) after 2 edges.
- Counter wrap: force 2^CNT_W accepted beats (or use CNT_W=2 and 5 beats) -> out_count returns to 0 then 1.
